// File: rtl/udp_ctrl_pkg.sv
// Shared register map, ID constant, CTRL bit indices and byte-lane merge helper for udp_ctrl_regs.
package udp_ctrl_pkg;

    localparam logic [3:0] REG_CTRL       = 4'h0;
    localparam logic [3:0] REG_MAC_LO     = 4'h1;
    localparam logic [3:0] REG_MAC_HI     = 4'h2;
    localparam logic [3:0] REG_LOCAL_IP   = 4'h3;
    localparam logic [3:0] REG_REMOTE_IP  = 4'h4;
    localparam logic [3:0] REG_PORTS      = 4'h5;
    localparam logic [3:0] REG_TX_PKT_CNT = 4'h6;
    localparam logic [3:0] REG_RX_PKT_CNT = 4'h7;
    localparam logic [3:0] REG_RX_ERR_CNT = 4'h8;
    localparam logic [3:0] REG_ID         = 4'h9;

    localparam logic [31:0] ID_VALUE = 32'h5544_5001;

    localparam int unsigned CTRL_ENABLE_BIT    = 0;
    localparam int unsigned CTRL_CLR_STATS_BIT = 1;

    function automatic logic [31:0] apply_strb(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) begin
                res[i*8 +: 8] = new_val[i*8 +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/udp_stat_counter.sv
// 32-bit saturating event counter with synchronous clear; clear takes priority over increment.
module udp_stat_counter (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        inc,
    output logic [31:0] count
);

    logic [31:0] count_q;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count_q <= '0;
        end else if (inc && (count_q != 32'hFFFF_FFFF)) begin
            count_q <= count_q + 32'd1;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/udp_ctrl_regs.sv
// UDPMaster control/status register bank with one-cycle read and write acknowledge.
// Statistics counters and CLR_STATS are built only when UDP_CTRL_STATS_EN is defined.
module udp_ctrl_regs
    import udp_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH          = 32,
    parameter int unsigned ADDR_WIDTH          = 16,
    parameter int unsigned STRB_WIDTH          = DATA_WIDTH / 8,
    parameter logic [47:0] DEFAULT_LOCAL_MAC   = 48'h02_00_00_00_00_01,
    parameter logic [31:0] DEFAULT_LOCAL_IP    = 32'hC0A8_0102,
    parameter logic [31:0] DEFAULT_REMOTE_IP   = 32'hC0A8_0101,
    parameter logic [15:0] DEFAULT_LOCAL_PORT  = 16'h04D2,
    parameter logic [15:0] DEFAULT_REMOTE_PORT = 16'h04D2
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic [ADDR_WIDTH-1:0] reg_wr_addr,
    input  logic [DATA_WIDTH-1:0] reg_wr_data,
    input  logic [STRB_WIDTH-1:0] reg_wr_strb,
    input  logic                  reg_wr_en,
    output logic                  reg_wr_wait,
    output logic                  reg_wr_ack,
    input  logic [ADDR_WIDTH-1:0] reg_rd_addr,
    input  logic                  reg_rd_en,
    output logic [DATA_WIDTH-1:0] reg_rd_data,
    output logic                  reg_rd_wait,
    output logic                  reg_rd_ack,

    output logic                  cfg_enable,
    output logic [47:0]           cfg_local_mac,
    output logic [31:0]           cfg_local_ip,
    output logic [31:0]           cfg_remote_ip,
    output logic [15:0]           cfg_local_port,
    output logic [15:0]           cfg_remote_port,

    input  logic                  stat_tx_pkt,
    input  logic                  stat_rx_pkt,
    input  logic                  stat_rx_err
);

    logic        enable_q;
    logic [47:0] mac_q;
    logic [31:0] local_ip_q;
    logic [31:0] remote_ip_q;
    logic [15:0] local_port_q;
    logic [15:0] remote_port_q;
    logic        wr_ack_q;
    logic        rd_ack_q;
    logic [31:0] rd_data_q;
    logic [31:0] rd_mux;
    logic [31:0] mac_hi_merged;
    logic [31:0] tx_cnt;
    logic [31:0] rx_cnt;
    logic [31:0] err_cnt;

    // A request fires only on the cycle it is first seen, never during its own ack cycle.
    logic       wr_fire;
    logic       rd_fire;
    logic       wr_mapped;
    logic       rd_mapped;
    logic [3:0] wr_idx;
    logic [3:0] rd_idx;
    logic       clr_stats;

    assign wr_fire   = reg_wr_en && !wr_ack_q;
    assign rd_fire   = reg_rd_en && !rd_ack_q;
    assign wr_mapped = (reg_wr_addr[ADDR_WIDTH-1:6] == '0);
    assign rd_mapped = (reg_rd_addr[ADDR_WIDTH-1:6] == '0);
    assign wr_idx    = reg_wr_addr[5:2];
    assign rd_idx    = reg_rd_addr[5:2];
    assign clr_stats = wr_fire && wr_mapped && (wr_idx == REG_CTRL) && reg_wr_strb[0] &&
                       reg_wr_data[CTRL_CLR_STATS_BIT];

    assign mac_hi_merged = apply_strb({16'h0000, mac_q[47:32]}, reg_wr_data, reg_wr_strb);

    always_ff @(posedge clk) begin
        if (rst) begin
            enable_q      <= 1'b0;
            mac_q         <= DEFAULT_LOCAL_MAC;
            local_ip_q    <= DEFAULT_LOCAL_IP;
            remote_ip_q   <= DEFAULT_REMOTE_IP;
            local_port_q  <= DEFAULT_LOCAL_PORT;
            remote_port_q <= DEFAULT_REMOTE_PORT;
            wr_ack_q      <= 1'b0;
        end else begin
            wr_ack_q <= wr_fire;
            if (wr_fire && wr_mapped) begin
                case (wr_idx)
                    REG_CTRL: begin
                        if (reg_wr_strb[0]) begin
                            enable_q <= reg_wr_data[CTRL_ENABLE_BIT];
                        end
                    end
                    REG_MAC_LO:    mac_q[31:0]  <= apply_strb(mac_q[31:0], reg_wr_data,
                                                              reg_wr_strb);
                    REG_MAC_HI:    mac_q[47:32] <= mac_hi_merged[15:0];
                    REG_LOCAL_IP:  local_ip_q   <= apply_strb(local_ip_q, reg_wr_data,
                                                              reg_wr_strb);
                    REG_REMOTE_IP: remote_ip_q  <= apply_strb(remote_ip_q, reg_wr_data,
                                                              reg_wr_strb);
                    REG_PORTS: {remote_port_q, local_port_q} <=
                        apply_strb({remote_port_q, local_port_q}, reg_wr_data, reg_wr_strb);
                    default: ;
                endcase
            end
        end
    end

`ifdef UDP_CTRL_STATS_EN
    udp_stat_counter u_tx_pkt_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr_stats),
        .inc   (stat_tx_pkt),
        .count (tx_cnt)
    );

    udp_stat_counter u_rx_pkt_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr_stats),
        .inc   (stat_rx_pkt),
        .count (rx_cnt)
    );

    udp_stat_counter u_rx_err_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr_stats),
        .inc   (stat_rx_err),
        .count (err_cnt)
    );

    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{reg_wr_addr[1:0], reg_rd_addr[1:0]};
`else
    assign tx_cnt  = '0;
    assign rx_cnt  = '0;
    assign err_cnt = '0;

    logic unused_stats;
    assign unused_stats = ^{stat_tx_pkt, stat_rx_pkt, stat_rx_err, clr_stats,
                            reg_wr_addr[1:0], reg_rd_addr[1:0]};
`endif

    always_comb begin
        rd_mux = '0;
        if (rd_mapped) begin
            case (rd_idx)
                REG_CTRL:       rd_mux = {31'h0, enable_q};
                REG_MAC_LO:     rd_mux = mac_q[31:0];
                REG_MAC_HI:     rd_mux = {16'h0000, mac_q[47:32]};
                REG_LOCAL_IP:   rd_mux = local_ip_q;
                REG_REMOTE_IP:  rd_mux = remote_ip_q;
                REG_PORTS:      rd_mux = {remote_port_q, local_port_q};
                REG_TX_PKT_CNT: rd_mux = tx_cnt;
                REG_RX_PKT_CNT: rd_mux = rx_cnt;
                REG_RX_ERR_CNT: rd_mux = err_cnt;
                REG_ID:         rd_mux = ID_VALUE;
                default:        rd_mux = '0;
            endcase
        end
    end

    // Sampling before the write edge lands gives read-before-write on a shared address.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ack_q  <= 1'b0;
            rd_data_q <= '0;
        end else begin
            rd_ack_q <= rd_fire;
            if (rd_fire) begin
                rd_data_q <= rd_mux;
            end
        end
    end

    assign reg_wr_wait     = 1'b0;
    assign reg_wr_ack      = wr_ack_q;
    assign reg_rd_wait     = 1'b0;
    assign reg_rd_ack      = rd_ack_q;
    assign reg_rd_data     = rd_data_q;

    assign cfg_enable      = enable_q;
    assign cfg_local_mac   = mac_q;
    assign cfg_local_ip    = local_ip_q;
    assign cfg_remote_ip   = remote_ip_q;
    assign cfg_local_port  = local_port_q;
    assign cfg_remote_port = remote_port_q;

endmodule

// File: tb/tb_udp_ctrl_regs.sv
// Scoreboard bench for udp_ctrl_regs; counter expectations follow UDP_CTRL_STATS_EN.
module tb_udp_ctrl_regs;

`ifdef UDP_CTRL_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] reg_wr_addr = '0;
    logic [31:0] reg_wr_data = '0;
    logic [3:0]  reg_wr_strb = '0;
    logic        reg_wr_en = 1'b0;
    logic        reg_wr_wait;
    logic        reg_wr_ack;
    logic [15:0] reg_rd_addr = '0;
    logic        reg_rd_en = 1'b0;
    logic [31:0] reg_rd_data;
    logic        reg_rd_wait;
    logic        reg_rd_ack;
    logic        cfg_enable;
    logic [47:0] cfg_local_mac;
    logic [31:0] cfg_local_ip;
    logic [31:0] cfg_remote_ip;
    logic [15:0] cfg_local_port;
    logic [15:0] cfg_remote_port;
    logic        stat_tx_pkt = 1'b0;
    logic        stat_rx_pkt = 1'b0;
    logic        stat_rx_err = 1'b0;

    udp_ctrl_regs dut (
        .clk             (clk),
        .rst             (rst),
        .reg_wr_addr     (reg_wr_addr),
        .reg_wr_data     (reg_wr_data),
        .reg_wr_strb     (reg_wr_strb),
        .reg_wr_en       (reg_wr_en),
        .reg_wr_wait     (reg_wr_wait),
        .reg_wr_ack      (reg_wr_ack),
        .reg_rd_addr     (reg_rd_addr),
        .reg_rd_en       (reg_rd_en),
        .reg_rd_data     (reg_rd_data),
        .reg_rd_wait     (reg_rd_wait),
        .reg_rd_ack      (reg_rd_ack),
        .cfg_enable      (cfg_enable),
        .cfg_local_mac   (cfg_local_mac),
        .cfg_local_ip    (cfg_local_ip),
        .cfg_remote_ip   (cfg_remote_ip),
        .cfg_local_port  (cfg_local_port),
        .cfg_remote_port (cfg_remote_port),
        .stat_tx_pkt     (stat_tx_pkt),
        .stat_rx_pkt     (stat_rx_pkt),
        .stat_rx_err     (stat_rx_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every read ack pops one expected value.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (reg_rd_ack === 1'b1) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_rd_ack: got data %0h, expected no ack", reg_rd_data);
                end else begin
                    e = sb.pop_front();
                    check(e.name, {32'h0, reg_rd_data}, {32'h0, e.exp});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic do_read(input logic [15:0] addr, input logic [31:0] exp, input string name);
        sb.push_back('{name, exp});
        @(negedge clk);
        reg_rd_addr = addr;
        reg_rd_en   = 1'b1;
        @(posedge clk);
        #1;
        check({name, "_ack_latency"}, {63'h0, reg_rd_ack}, 64'h1);
        @(posedge clk);
        #1;
        check({name, "_ack_width"}, {63'h0, reg_rd_ack}, 64'h0);
        reg_rd_en = 1'b0;
    endtask

    task automatic do_write(input logic [15:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input string name);
        @(negedge clk);
        reg_wr_addr = addr;
        reg_wr_data = data;
        reg_wr_strb = strb;
        reg_wr_en   = 1'b1;
        @(posedge clk);
        #1;
        check({name, "_wr_ack"}, {63'h0, reg_wr_ack}, 64'h1);
        @(posedge clk);
        #1;
        check({name, "_wr_ack_width"}, {63'h0, reg_wr_ack}, 64'h0);
        reg_wr_en = 1'b0;
    endtask

    task automatic pulse(input int which, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            case (which)
                0:       stat_tx_pkt = 1'b1;
                1:       stat_rx_pkt = 1'b1;
                default: stat_rx_err = 1'b1;
            endcase
            @(negedge clk);
            stat_tx_pkt = 1'b0;
            stat_rx_pkt = 1'b0;
            stat_rx_err = 1'b0;
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_rd_ack", {63'h0, reg_rd_ack}, 64'h0);
        check("rst_wr_ack", {63'h0, reg_wr_ack}, 64'h0);
        check("rst_rd_data", {32'h0, reg_rd_data}, 64'h0);
        check("rst_enable", {63'h0, cfg_enable}, 64'h0);
        check("rst_mac", {16'h0, cfg_local_mac}, 64'h0000_0200_0000_0001);
        check("rst_local_ip", {32'h0, cfg_local_ip}, 64'hC0A8_0102);
        check("rst_remote_ip", {32'h0, cfg_remote_ip}, 64'hC0A8_0101);
        check("rst_ports", {32'h0, cfg_remote_port, cfg_local_port}, 64'h04D2_04D2);

        do_read(16'h0024, 32'h5544_5001, "rd_id");
        do_read(16'h0004, 32'h0000_0001, "rd_mac_lo");
        do_read(16'h0008, 32'h0000_0200, "rd_mac_hi");
        do_read(16'h0018, 32'h0000_0000, "rd_tx_cnt_rst");

        do_write(16'h0014, 32'hABCD_1234, 4'b0011, "wr_ports");
        check("ports_local", {48'h0, cfg_local_port}, 64'h1234);
        check("ports_remote", {48'h0, cfg_remote_port}, 64'h04D2);
        do_read(16'h0014, 32'h04D2_1234, "rd_ports");

        do_write(16'h0008, 32'hFFFF_AABB, 4'b1111, "wr_mac_hi");
        check("mac_after_hi", {16'h0, cfg_local_mac}, 64'h0000_AABB_0000_0001);
        do_read(16'h0008, 32'h0000_AABB, "rd_mac_hi_new");

        pulse(1, 5);
        do_read(16'h001C, STATS ? 32'd5 : 32'd0, "rd_rx_cnt5");
`ifdef UDP_CTRL_STATS_EN
        @(negedge clk);
        force dut.u_rx_pkt_cnt.count_q = 32'hFFFF_FFFE;
        @(negedge clk);
        release dut.u_rx_pkt_cnt.count_q;
        pulse(1, 3);
        do_read(16'h001C, 32'hFFFF_FFFF, "rd_rx_cnt_sat");
`endif
        pulse(2, 1);
        do_read(16'h0020, STATS ? 32'd1 : 32'd0, "rd_err_cnt");

        pulse(0, 2);
        do_read(16'h0018, STATS ? 32'd2 : 32'd0, "rd_tx_cnt2");
        fork
            do_write(16'h0000, 32'h0000_0003, 4'b1111, "wr_ctrl_clr");
            begin
                @(negedge clk);
                stat_tx_pkt = 1'b1;
                @(negedge clk);
                stat_tx_pkt = 1'b0;
            end
        join
        check("ctrl_enable", {63'h0, cfg_enable}, 64'h1);
        do_read(16'h0018, 32'h0, "rd_tx_cnt_clr");
        do_read(16'h001C, 32'h0, "rd_rx_cnt_clr");
        do_read(16'h0000, 32'h1, "rd_ctrl");

        fork
            do_read(16'h000C, 32'hC0A8_0102, "rd_ip_rbw");
            do_write(16'h000C, 32'h0A00_0001, 4'b1111, "wr_ip");
        join
        do_read(16'h000C, 32'h0A00_0001, "rd_ip_new");

        do_write(16'h003C, 32'hFFFF_FFFF, 4'b1111, "wr_3c");
        do_write(16'h0040, 32'h0000_0000, 4'b1111, "wr_40");
        do_write(16'h0018, 32'h1234_5678, 4'b1111, "wr_ro");
        do_read(16'h0040, 32'h0, "rd_40");
        do_read(16'h003C, 32'h0, "rd_3c");
        do_read(16'h0018, 32'h0, "rd_tx_after_ro_wr");
        check("unm_enable", {63'h0, cfg_enable}, 64'h1);
        check("unm_mac", {16'h0, cfg_local_mac}, 64'h0000_AABB_0000_0001);
        check("unm_local_ip", {32'h0, cfg_local_ip}, 64'h0A00_0001);
        check("unm_remote_ip", {32'h0, cfg_remote_ip}, 64'hC0A8_0101);
        check("unm_ports", {32'h0, cfg_remote_port, cfg_local_port}, 64'h04D2_1234);

        @(negedge clk);
        reg_rd_addr = 16'h0024;
        reg_rd_en   = 1'b1;
        rst         = 1'b1;
        @(posedge clk);
        #1;
        check("rst_mid_ack", {63'h0, reg_rd_ack}, 64'h0);
        @(negedge clk);
        rst       = 1'b0;
        reg_rd_en = 1'b0;
        @(posedge clk);
        #1;
        check("rst_mid_ack2", {63'h0, reg_rd_ack}, 64'h0);
        check("rst_mid_data", {32'h0, reg_rd_data}, 64'h0);
        check("rst_mid_enable", {63'h0, cfg_enable}, 64'h0);
        check("rst_mid_ip", {32'h0, cfg_local_ip}, 64'hC0A8_0102);

        repeat (2) @(negedge clk);
        check("sb_drained", {32'h0, 32'(sb.size())}, 64'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
